// File: rtl/i2c_slave_if.sv
// i2c_slave_if: I2C slave front end for a single 7-bit address.
//
// Samples scl/sda through 2-flop synchronizers and runs the slave protocol FSM
// in the clk domain. Write bytes from the master are presented on rx_data
// together with a 1-cycle rx_valid pulse. Read bytes are requested with a
// 1-cycle tx_req pulse and taken from tx_data. sda is open-drain: the block
// only ever pulls it to 0.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset
//   scl      bus clock from the master (input only)
//   sda      bus data, driven to 0 or left at Z
//   tx_data  read byte supplied by the user
//   tx_req   1-cycle pulse requesting the next read byte
//   rx_data  last byte written by the master
//   rx_valid 1-cycle pulse when rx_data is updated
//   busy     high from address match until STOP, repeated START or NACK
module i2c_slave_if #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    logic       scl_meta, scl_s, scl_d;
    logic       sda_meta, sda_s, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] shift_in;
    logic       rw;
    // Set when the current byte/bit phase is complete and the next scl_fall
    // must act (drive ACK, or load the next read byte).
    logic       pend;
    logic       sda_oe;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;
    assign shift_in  = {shift_reg[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_meta  <= 1'b1;
            scl_s     <= 1'b1;
            scl_d     <= 1'b1;
            sda_meta  <= 1'b1;
            sda_s     <= 1'b1;
            sda_d     <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= 3'd7;
            shift_reg <= 8'h00;
            rw        <= 1'b0;
            pend      <= 1'b0;
            sda_oe    <= 1'b0;
            tx_req    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            scl_meta <= scl;
            scl_s    <= scl_meta;
            scl_d    <= scl_s;
            sda_meta <= sda;
            sda_s    <= sda_meta;
            sda_d    <= sda_s;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd7;
                pend    <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                pend   <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && !pend) begin
                            shift_reg <= shift_in;
                            if (bit_cnt == 3'd0) begin
                                if (shift_in[7:1] == SLAVE_ADDR) begin
                                    rw     <= shift_in[0];
                                    busy   <= 1'b1;
                                    pend   <= 1'b1;
                                    tx_req <= shift_in[0];
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end else if (scl_fall && pend) begin
                            sda_oe <= 1'b1;
                            pend   <= 1'b0;
                            state  <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd7;
                            if (rw) begin
                                shift_reg <= tx_data;
                                sda_oe    <= ~tx_data[7];
                                state     <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && !pend) begin
                            shift_reg <= shift_in;
                            if (bit_cnt == 3'd0) begin
                                rx_data  <= shift_in;
                                rx_valid <= 1'b1;
                                pend     <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end else if (scl_fall && pend) begin
                            sda_oe <= 1'b1;
                            pend   <= 1'b0;
                            state  <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                sda_oe    <= ~shift_reg[6];
                                bit_cnt   <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && !pend) begin
                            if (!sda_s) begin
                                tx_req <= 1'b1;
                                pend   <= 1'b1;
                            end else begin
                                // sda is already released in this state.
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end else if (scl_fall && pend) begin
                            shift_reg <= tx_data;
                            sda_oe    <= ~tx_data[7];
                            bit_cnt   <= 3'd7;
                            pend      <= 1'b0;
                            state     <= RD_DATA;
                        end
                    end
                    default: begin
                        // IDLE and IGNORE leave only on START/STOP.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_if.sv
// Bench for i2c_slave_if: a bit-banged I2C master drives directed
// transactions; expected values are queued as stimulus is issued and a
// monitor process compares them against what the DUT presents.
module tb_i2c_slave_if;

    logic       clk;
    logic       rst;
    logic       m_scl;
    logic       m_sda_low;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    wire        sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_if #(
        .SLAVE_ADDR(7'h50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (m_scl),
        .sda     (sda),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;

    // Scoreboard queues.
    logic [7:0] exp_rx[$];
    logic [7:0] txq[$];
    string      exp_name[$];
    logic [7:0] exp_val[$];
    string      obs_name[$];
    logic [7:0] obs_val[$];

    // Monitor: compares every DUT output event against the queued expectation.
    always @(negedge clk) begin
        string      on, en;
        logic [7:0] ov, ev;
        if (rx_valid === 1'b1) begin
            n_vec++;
            if (exp_rx.size() == 0) begin
                n_bad++;
                $display("FAIL rx_valid: unexpected pulse with rx_data=%02h, expected none",
                         rx_data);
            end else begin
                ev = exp_rx.pop_front();
                if (rx_data !== ev) begin
                    n_bad++;
                    $display("FAIL rx_data: got %02h, expected %02h", rx_data, ev);
                end
            end
        end
        if (tx_req === 1'b1) begin
            n_vec++;
            if (txq.size() == 0) begin
                n_bad++;
                $display("FAIL tx_req: unexpected pulse, got 1, expected 0");
            end else begin
                tx_data = txq.pop_front();
            end
        end
        while (obs_name.size() > 0) begin
            n_vec++;
            on = obs_name.pop_front();
            ov = obs_val.pop_front();
            if (exp_name.size() == 0) begin
                n_bad++;
                $display("FAIL %s: got %02h, no value expected", on, ov);
            end else begin
                en = exp_name.pop_front();
                ev = exp_val.pop_front();
                if (on != en || ov !== ev) begin
                    n_bad++;
                    $display("FAIL %s: got %02h, expected %s=%02h", on, ov, en, ev);
                end
            end
        end
    end

    task automatic expect_ev(input string name, input logic [7:0] v);
        exp_name.push_back(name);
        exp_val.push_back(v);
    endtask

    task automatic observe(input string name, input logic [7:0] v);
        obs_name.push_back(name);
        obs_val.push_back(v);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus primitives: scl half-period is 10 clk cycles; sda changes mid-low.
    task automatic bus_start();
        m_scl = 1'b0;
        wait_cyc(5);
        m_sda_low = 1'b0;
        wait_cyc(5);
        m_scl = 1'b1;
        wait_cyc(10);
        m_sda_low = 1'b1;
        wait_cyc(10);
        m_scl = 1'b0;
        wait_cyc(5);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_cyc(5);
        m_scl = 1'b1;
        wait_cyc(10);
        m_sda_low = 1'b0;
        wait_cyc(10);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        wait_cyc(5);
        m_scl = 1'b1;
        wait_cyc(10);
        m_scl = 1'b0;
        wait_cyc(5);
    endtask

    task automatic recv_bit(output logic r);
        m_sda_low = 1'b0;
        wait_cyc(5);
        m_scl = 1'b1;
        wait_cyc(6);
        r = sda;
        wait_cyc(4);
        m_scl = 1'b0;
        wait_cyc(5);
    endtask

    // Send a byte and check the ACK slot against exp_ack.
    task automatic wr(input string name, input logic [7:0] b, input logic exp_ack);
        logic a;
        expect_ev(name, {7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        observe(name, {7'd0, a});
    endtask

    // Receive a byte, then answer with ACK (0) or NACK (1).
    task automatic rd(input string name, input logic [7:0] exp_b, input logic nack);
        logic [7:0] b;
        logic       r;
        expect_ev(name, exp_b);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(r);
            b[i] = r;
        end
        observe(name, b);
        send_bit(nack);
    endtask

    task automatic chk_busy(input string name, input logic e);
        expect_ev(name, {7'd0, e});
        observe(name, {7'd0, busy});
    endtask

    initial begin
        rst       = 1'b0;
        m_scl     = 1'b1;
        m_sda_low = 1'b0;
        wait_cyc(4);

        // Reset state
        expect_ev("rst_rx_data", 8'h00);  observe("rst_rx_data", rx_data);
        expect_ev("rst_rx_valid", 8'h00); observe("rst_rx_valid", {7'd0, rx_valid});
        expect_ev("rst_tx_req", 8'h00);   observe("rst_tx_req", {7'd0, tx_req});
        chk_busy("rst_busy", 1'b0);
        expect_ev("rst_sda", 8'h01);      observe("rst_sda", {7'd0, sda});
        rst = 1'b1;
        wait_cyc(10);

        // Matching address clocked without a START must be ignored
        m_scl = 1'b0;
        wait_cyc(10);
        wr("nostart_ack", 8'hA0, 1'b1);
        chk_busy("nostart_busy", 1'b0);

        // Write A0, 3C
        exp_rx.push_back(8'h3C);
        bus_start();
        wr("w_addr_ack", 8'hA0, 1'b0);
        chk_busy("w_busy", 1'b1);
        wr("w_data_ack", 8'h3C, 1'b0);
        bus_stop();
        chk_busy("w_busy_stop", 1'b0);
        m_scl = 1'b0;
        wait_cyc(10);

        // Read 2 bytes, ACK then NACK
        txq.push_back(8'h96);
        txq.push_back(8'h5A);
        bus_start();
        wr("r_addr_ack", 8'hA1, 1'b0);
        rd("r_byte0", 8'h96, 1'b0);
        rd("r_byte1", 8'h5A, 1'b1);
        expect_ev("r_sda_rel", 8'h01); observe("r_sda_rel", {7'd0, sda});
        chk_busy("r_busy_nack", 1'b0);
        bus_stop();
        m_scl = 1'b0;
        wait_cyc(10);

        // Wrong address
        bus_start();
        wr("x_addr_ack", 8'h42, 1'b1);
        chk_busy("x_busy", 1'b0);
        wr("x_data_ack", 8'h11, 1'b1);
        bus_stop();
        chk_busy("x_busy_stop", 1'b0);
        m_scl = 1'b0;
        wait_cyc(10);

        // Repeated START: write 01, then read 77
        exp_rx.push_back(8'h01);
        txq.push_back(8'h77);
        bus_start();
        wr("rs_waddr_ack", 8'hA0, 1'b0);
        wr("rs_wdata_ack", 8'h01, 1'b0);
        bus_start();
        chk_busy("rs_busy_restart", 1'b0);
        wr("rs_raddr_ack", 8'hA1, 1'b0);
        rd("rs_rbyte", 8'h77, 1'b1);
        bus_stop();
        m_scl = 1'b0;
        wait_cyc(10);

        // Reset after 4 bits of a data byte, then a normal write
        bus_start();
        wr("rm_addr_ack", 8'hA0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        m_sda_low = 1'b0;
        rst = 1'b0;
        wait_cyc(2);
        expect_ev("rm_sda_rel", 8'h01); observe("rm_sda_rel", {7'd0, sda});
        chk_busy("rm_busy", 1'b0);
        rst = 1'b1;
        wait_cyc(10);
        exp_rx.push_back(8'h55);
        bus_start();
        wr("rm2_addr_ack", 8'hA0, 1'b0);
        wr("rm2_data_ack", 8'h55, 1'b0);
        bus_stop();
        m_scl = 1'b0;
        wait_cyc(10);

        // Back-to-back writes FF, 00
        exp_rx.push_back(8'hFF);
        exp_rx.push_back(8'h00);
        bus_start();
        wr("bb_addr_ack", 8'hA0, 1'b0);
        wr("bb_d0_ack", 8'hFF, 1'b0);
        wr("bb_d1_ack", 8'h00, 1'b0);
        bus_stop();
        chk_busy("bb_busy_stop", 1'b0);
        wait_cyc(10);

        // Every expected rx_valid and tx_req pulse must have been consumed
        expect_ev("rx_left", 8'h00); observe("rx_left", 8'(exp_rx.size()));
        expect_ev("tx_left", 8'h00); observe("tx_left", 8'(txq.size()));
        wait_cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_if.md
I2C_SLAVE_IF -- requirements
Module: i2c_slave_if

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, giving the 7-bit address the block answers to.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock, on whose rising edge all logic is clocked.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port scl, input, 1 bit: the bus clock driven by the master, never driven by this block.
REQ-005 The block SHALL have port sda, inout, 1 bit: the bus data line, which this block drives only to 0 and otherwise leaves at Z.
REQ-006 The block SHALL have port tx_data, input, 8 bits: the read byte supplied by the user, which must be valid when tx_req pulses.
REQ-007 The block SHALL have port tx_req, output, 1 bit: a 1-cycle pulse requesting the next read byte.
REQ-008 The block SHALL have port rx_data, output, 8 bits: the last byte written by the master.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: a 1-cycle pulse indicating rx_data has been updated.
REQ-010 The block SHALL have port busy, output, 1 bit: high from address match until STOP, repeated START or NACK.

Function
REQ-011 scl and sda SHALL each pass through a 2-flop synchronizer (scl_s, sda_s) before any use.
REQ-012 Edges SHALL be derived from the synchronized signals and their 1-cycle-delayed copies: scl_rise, scl_fall, START (sda_s falls while scl_s=1), STOP (sda_s rises while scl_s=1).
REQ-013 Correct operation SHALL be required only when every scl high phase and every scl low phase lasts at least 4 clk cycles.
REQ-014 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and IGNORE.
REQ-015 START detected in any state, including a repeated START, SHALL move the FSM to ADDR, set bit_cnt=7, release sda and clear busy.
REQ-016 STOP detected in any state SHALL move the FSM to IDLE, release sda and clear busy.
REQ-017 In ADDR, each scl_rise SHALL shift sda_s into shift_reg MSB-first.
REQ-018 On the 8th scl_rise in ADDR, if shift_reg[7:1]==SLAVE_ADDR the block SHALL latch rw=bit0 and set busy; otherwise it SHALL go to IGNORE and never drive sda.
REQ-019 For a matched address with rw=1, tx_req SHALL pulse on the same 8th scl_rise.
REQ-020 After a match, the next scl_fall SHALL drive sda=0 (ACK) and enter ADDR_ACK.
REQ-021 On the scl_fall that ends the ACK bit with rw=0, the block SHALL release sda and enter WR_DATA with bit_cnt=7.
REQ-022 On the scl_fall that ends the ACK bit with rw=1, the block SHALL latch tx_data into shift_reg, drive bit7 (sda=0 when the bit is 0, Z when it is 1) and enter RD_DATA.
REQ-023 In WR_DATA, each scl_rise SHALL sample a bit; on the 8th, the cycle after it SHALL load rx_data and pulse rx_valid for exactly 1 cycle.
REQ-024 After the 8th WR_DATA bit, the next scl_fall SHALL drive ACK and enter WR_ACK; the following scl_fall SHALL release sda and return to WR_DATA with bit_cnt=7.
REQ-025 In RD_DATA, each scl_fall SHALL present the next bit.
REQ-026 After the 8th RD_DATA bit, the next scl_fall SHALL release sda and enter RD_ACK.
REQ-027 In RD_ACK, on scl_rise with sda_s=0 (ACK), tx_req SHALL pulse and the next scl_fall SHALL load tx_data and drive its bit7 in RD_DATA.
REQ-028 In RD_ACK, on scl_rise with sda_s=1 (NACK), the block SHALL clear busy, release sda and enter IGNORE.
REQ-029 bit_cnt SHALL be 3 bits and count down 7 to 0 with no wrap; reaching 0 ends the byte.
REQ-030 The sda enable SHALL be registered and change only on scl_fall, START, STOP or reset, never while scl_s=1 except on START/STOP release.
REQ-031 IGNORE SHALL exit only on START or STOP.

Reset
REQ-032 When rst=0 at a clk edge, the FSM SHALL go to IDLE and sda SHALL be released (Z).
REQ-033 While rst=0, rx_data SHALL be 8'h00, rx_valid=0, tx_req=0, busy=0, bit_cnt=7, shift_reg=0, and the synchronizers SHALL be 1.
REQ-034 Reset asserted mid-transfer SHALL abort with no ACK driven and no rx_valid pulse.
REQ-035 After reset is released, the block SHALL wait for a START; bus activity without a START SHALL be ignored.

Verification
REQ-036 Write: START, 0xA0, 0x3C, STOP -> ACK after both bytes, rx_data=8'h3C, exactly 1 rx_valid pulse, busy 0 after STOP.
REQ-037 Read 2 bytes: START, 0xA1; tx_data=0x96 then 0x5A; master ACKs byte 1 and NACKs byte 2 -> master receives 0x96 and 0x5A, 2 tx_req pulses, sda released after the NACK.
REQ-038 Wrong address: START, 0x42, 0x11, STOP -> sda never driven, no rx_valid, busy stays 0.
REQ-039 Repeated START: write 0xA0, 0x01, then repeated START, 0xA1 with tx_data=0x77 -> rx_data=8'h01, then master reads 0x77.
REQ-040 Reset mid-write: rst=0 after 4 bits of a data byte -> sda released next cycle, no rx_valid, and the block answers normally after the next START.
REQ-041 Back-to-back writes: START, 0xA0, 0xFF, 0x00, STOP -> 2 rx_valid pulses with rx_data 8'hFF then 8'h00.
